// File: rtl/lsu_pkg.sv
// Shared types and width encodings for the load/store unit.
// Width codes follow the RV32I funct3 field.
package lsu_pkg;

    localparam logic [2:0] MW_B  = 3'b000;
    localparam logic [2:0] MW_H  = 3'b001;
    localparam logic [2:0] MW_W  = 3'b010;
    localparam logic [2:0] MW_BU = 3'b100;
    localparam logic [2:0] MW_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } lsu_state_t;

    function automatic logic access_illegal(
        input logic [2:0] width,
        input logic [1:0] lo
    );
        case (width)
            MW_B, MW_BU: return 1'b0;
            MW_H, MW_HU: return lo[0];
            MW_W:        return |lo;
            default:     return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed lane of a bus word and extends it
// to 32 bits according to the load width.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  width,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        data = shifted;
        case (width)
            MW_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            MW_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            MW_BU:   data = {24'b0, shifted[7:0]};
            MW_HU:   data = {16'b0, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory interface: req/ack bus transaction,
// store lane steering, load extension, fault and timeout reporting.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_width,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        access_fault,
    output logic        bus_error,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    lsu_state_t  state;
    logic [2:0]  width_q;
    logic [1:0]  offset_q;
    logic [WW-1:0] wait_cnt;

    logic        pending;
    logic        fault;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] ext_data;

    assign pending = mem_read | mem_write;
    assign fault   = access_illegal(mem_width, address[1:0]);

    assign stall = !reset &&
        ((state == IDLE && pending && !fault) || state == REQ);
    assign access_fault = !reset && state == IDLE && pending && fault;

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = store_data;
        case (mem_width)
            MW_B, MW_BU: begin
                be_next    = 4'b0001 << address[1:0];
                wdata_next = {4{store_data[7:0]}};
            end
            MW_H, MW_HU: begin
                be_next    = 4'b0011 << {address[1], 1'b0};
                wdata_next = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    load_extend u_ext (
        .rdata  (bus_rdata),
        .offset (offset_q),
        .width  (width_q),
        .data   (ext_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_be    <= 4'b0;
            bus_addr  <= 32'b0;
            bus_wdata <= 32'b0;
            load_data <= 32'b0;
            bus_error <= 1'b0;
            width_q   <= 3'b0;
            offset_q  <= 2'b0;
            wait_cnt  <= '0;
        end else begin
            bus_error <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pending && fault) begin
                        load_data <= 32'b0;
                    end else if (pending) begin
                        bus_addr  <= {address[31:2], 2'b00};
                        bus_we    <= mem_write;
                        bus_be    <= be_next;
                        bus_wdata <= wdata_next;
                        width_q   <= mem_width;
                        offset_q  <= address[1:0];
                        wait_cnt  <= '0;
                        bus_req   <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        if (!bus_we) load_data <= ext_data;
                        bus_req <= 1'b0;
                        state   <= DONE;
                    end else if (wait_cnt == WW'(MAX_WAIT - 1)) begin
                        bus_req   <= 1'b0;
                        load_data <= 32'b0;
                        bus_error <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                // inputs are still held here; skip straight back
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized bench for load_store_unit with a
// arithmetic reference model of lanes, extension and timing.
module tb_load_store_unit;

    localparam int MAXW = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [2:0]  mem_width;
    logic [31:0] address, store_data;
    logic [31:0] load_data;
    logic        stall, access_fault, bus_error;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_ld = 32'b0;

    always #5 clk = ~clk;

    load_store_unit #(.MAX_WAIT(MAXW)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_width    (mem_width),
        .address      (address),
        .store_data   (store_data),
        .load_data    (load_data),
        .stall        (stall),
        .access_fault (access_fault),
        .bus_error    (bus_error),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_be       (bus_be),
        .bus_rdata    (bus_rdata),
        .bus_ack      (bus_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int m_size(input logic [2:0] w);
        case (w)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit m_fault(input logic [2:0] w, input logic [31:0] a);
        int sz = m_size(w);
        if (sz == 0) return 1'b1;
        return (a % sz) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] w, input logic [31:0] a);
        int sz = m_size(w);
        int v = ((1 << sz) - 1) << (a % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] w, input logic [31:0] sd);
        int sz = m_size(w);
        if (sz == 1) return {24'b0, sd[7:0]} * 32'h01010101;
        if (sz == 2) return {16'b0, sd[15:0]} * 32'h00010001;
        return sd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] w, input logic [31:0] a,
                                           input logic [31:0] rd);
        int sz = m_size(w);
        longint v, mask;
        if (sz == 4) return rd;
        mask = (64'sd1 <<< (8 * sz)) - 1;
        v = (longint'(rd) >>> (8 * (a % 4))) & mask;
        if (w[2] == 1'b0 && v >= (mask + 1) / 2) v = v - (mask + 1);
        return v[31:0];
    endfunction

    // Drives one access starting just after a rising edge; delay<0 = no ack.
    task automatic run_access(input bit wr, input bit rd, input logic [2:0] w,
                              input logic [31:0] a, input logic [31:0] sd,
                              input logic [31:0] rdat, input int delay,
                              input string tag);
        int  n_stall = 0;
        int  n_req = 0;
        bit  done = 0;
        bit  timeout = (delay < 0);
        mem_write = wr; mem_read = rd; mem_width = w;
        address = a; store_data = sd; bus_rdata = rdat; bus_ack = 1'b0;
        if (m_fault(w, a)) begin
            @(negedge clk);
            chk({tag, " fault"}, 32'(access_fault), 32'd1);
            chk({tag, " fault_stall"}, 32'(stall), 32'd0);
            chk({tag, " fault_req"}, 32'(bus_req), 32'd0);
            @(posedge clk); #1;
            exp_ld = 32'b0;
            chk({tag, " fault_ld"}, load_data, exp_ld);
            mem_read = 1'b0; mem_write = 1'b0;
            @(negedge clk);
            chk({tag, " fault_pulse"}, 32'(access_fault), 32'd0);
            chk({tag, " fault_req2"}, 32'(bus_req), 32'd0);
            @(posedge clk); #1;
            return;
        end
        for (int c = 0; c < MAXW + 20 && !done; c++) begin
            @(negedge clk);
            if (stall) n_stall++;
            if (bus_req) begin
                if (n_req == 0) begin
                    chk({tag, " addr"}, bus_addr, {a[31:2], 2'b00});
                    chk({tag, " be"}, 32'(bus_be), 32'(m_be(w, a)));
                    chk({tag, " we"}, 32'(bus_we), 32'(wr));
                    if (wr) chk({tag, " wdata"}, bus_wdata, m_wdata(w, sd));
                end
                if (n_req == delay) bus_ack = 1'b1;
                n_req++;
            end else if (c > 0) begin
                done = 1;
                if (!wr) exp_ld = timeout ? 32'b0 : m_load(w, a, rdat);
                if (timeout) exp_ld = 32'b0;
                chk({tag, " stall_done"}, 32'(stall), 32'd0);
                chk({tag, " load"}, load_data, exp_ld);
                chk({tag, " bus_error"}, 32'(bus_error), 32'(timeout));
                chk({tag, " stall_cycles"}, n_stall,
                    timeout ? MAXW + 1 : delay + 2);
                if (timeout) chk({tag, " req_cycles"}, n_req, MAXW);
            end
            @(posedge clk); #1;
            bus_ack = 1'b0;
        end
        chk({tag, " completed"}, 32'(done), 32'd1);
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        chk({tag, " idle_err"}, 32'(bus_error), 32'd0);
        chk({tag, " idle_req"}, 32'(bus_req), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [2:0]  w;
        logic [1:0]  rw;
        reset = 1'b1;
        mem_read = 1'b1; mem_write = 1'b0; mem_width = 3'b010;
        address = 32'h100; store_data = 32'b0;
        bus_rdata = 32'b0; bus_ack = 1'b0;
        #12;
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst req", 32'(bus_req), 32'd0);
        chk("rst we", 32'(bus_we), 32'd0);
        chk("rst be", 32'(bus_be), 32'd0);
        chk("rst addr", bus_addr, 32'd0);
        chk("rst wdata", bus_wdata, 32'd0);
        chk("rst ld", load_data, 32'd0);
        chk("rst fault", 32'(access_fault), 32'd0);
        chk("rst err", 32'(bus_error), 32'd0);
        mem_read = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        run_access(1, 0, 3'b000, 32'h1003, 32'h000000AB, 32'h0, 0, "sb");
        run_access(0, 1, 3'b000, 32'h2001, 32'h0, 32'h0000F000, 0, "lb");
        run_access(0, 1, 3'b100, 32'h2001, 32'h0, 32'h0000F000, 0, "lbu");
        run_access(0, 1, 3'b001, 32'h3002, 32'h0, 32'h80010000, 3, "lh");
        run_access(0, 1, 3'b010, 32'h4002, 32'h0, 32'h0, 0, "lw_mis");
        run_access(0, 1, 3'b101, 32'h4004, 32'h0, 32'h12348765, 1, "lhu");
        run_access(0, 1, 3'b011, 32'h4000, 32'h0, 32'h0, 0, "w011");
        run_access(0, 1, 3'b010, 32'h4008, 32'h0, 32'hCAFEF00D, 2, "lw");
        run_access(1, 1, 3'b001, 32'h500A, 32'h0000BEEF, 32'h0, 1, "sh_both");
        run_access(0, 1, 3'b010, 32'h6000, 32'h0, 32'h11111111, -1, "lw_to");

        mem_read = 1'b1; mem_width = 3'b010; address = 32'h7000;
        @(negedge clk);
        chk("rr stall", 32'(stall), 32'd1);
        @(negedge clk);
        chk("rr req", 32'(bus_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rr req_drop", 32'(bus_req), 32'd0);
        chk("rr stall_drop", 32'(stall), 32'd0);
        mem_read = 1'b0;
        exp_ld = 32'b0;
        @(negedge clk); reset = 1'b0;
        bus_rdata = 32'hDEADBEEF; bus_ack = 1'b1;
        @(negedge clk);
        chk("rr late_req", 32'(bus_req), 32'd0);
        chk("rr late_ld", load_data, exp_ld);
        chk("rr late_stall", 32'(stall), 32'd0);
        chk("rr late_err", 32'(bus_error), 32'd0);
        bus_ack = 1'b0;
        @(posedge clk); #1;
        run_access(0, 1, 3'b100, 32'h7003, 32'h0, 32'h9A000000, 0, "post_rst");

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0: w = 3'b000;
                1: w = 3'b001;
                2: w = 3'b010;
                3: w = 3'b100;
                4: w = 3'b101;
                5: w = 3'b010;
                6: w = 3'b011;
                default: w = 3'b110;
            endcase
            rw = 2'($urandom_range(1, 3));
            run_access(rw[1], rw[0], w, $urandom, $urandom, $urandom,
                       $urandom_range(0, 4), $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1);
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory interface for the RV32I core, directly downstream of the instruction decoder. It consumes the decoder's `mem_write` and `mem_width` controls, plus a load request, the ALU-computed address and rs2 store data. It runs a request/acknowledge transaction on a 32-bit byte-enabled data bus and returns the aligned, sign- or zero-extended load result to the writeback mux. It stalls the core while a transaction is outstanding, and reports misaligned or illegal accesses and bus timeouts.

## Interface
- `MAX_WAIT`, default 255: number of `REQ` cycles without `bus_ack` before the access is aborted with a bus error.
- `clk` in 1: core clock; all state is updated on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `mem_read` in 1: load request; the core drives it high when `result_src` selects memory.
- `mem_write` in 1: store request, from the decoder.
- `mem_width` in 3: access width, using the funct3 encoding: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `address` in 32: byte address from the ALU.
- `store_data` in 32: rs2 value.
- `load_data` out 32: extended load result; registered.
- `stall` out 1: holds PC and pipeline registers.
- `access_fault` out 1: one-cycle pulse for a misaligned access or an illegal width.
- `bus_error` out 1: one-cycle pulse on timeout.
- `bus_req` out 1, `bus_we` out 1, `bus_addr` out 32 (bits [1:0] are always 0), `bus_wdata` out 32, `bus_be` out 4: bus request fields.
- `bus_rdata` in 32, `bus_ack` in 1: bus response.

## Operation
- FSM states: `IDLE`, `REQ`, `DONE`. Reset state is `IDLE`.
- An access is pending when `mem_read | mem_write`. If both are high, the access is a write.
- Fault check in `IDLE` with an access pending:
  - An access is a fault if the width is illegal (011, 110, 111), or a halfword has `address[0]`=1, or a word has `address[1:0]`≠0.
  - On a fault: `access_fault`=1 that cycle, `stall`=0, no bus activity, `load_data` cleared to 0, state stays `IDLE`.
- Aligned access in `IDLE`:
  - `stall`=1 combinationally.
  - On the next edge, latch `bus_addr`={address[31:2],2'b00}, `bus_we`, `bus_be`, `bus_wdata`, the width and the lane offset, then go to `REQ`.
- Store lanes:
  - Byte: be=4'b0001<<a[1:0], wdata={4{sd[7:0]}}.
  - Halfword: be=4'b0011<<{a[1],1'b0}, wdata={2{sd[15:0]}}.
  - Word: be=4'b1111, wdata=sd.
  - For loads, `bus_be` uses the same lane pattern.
- `REQ` state:
  - `bus_req`=1 and `stall`=1; all bus fields are held stable.
  - On `bus_ack`: for a read, capture the lane of `bus_rdata` into `load_data`, extended per the width (000/001 sign-extend, 100/101 zero-extend, 010 unchanged). Then go to `DONE`.
  - The wait counter increments each `REQ` cycle without ack. When it reaches `MAX_WAIT`: drop `bus_req`, clear `load_data` to 0, pulse `bus_error` in the following `DONE` cycle, and go to `DONE`.
- `DONE` state:
  - `stall`=0; the core advances at this edge.
  - The state goes to `IDLE` unconditionally, so the still-present inputs do not retrigger the access.
- `load_data` holds its value until the next completed load, fault or timeout.

## Timing
- Reset values: `bus_req`, `bus_we`, `bus_be`, `bus_addr`, `bus_wdata`, `load_data`, `access_fault` and `bus_error` are all 0. `stall` is forced to 0 while `reset` is high.
- Reset mid-transaction: the FSM returns to `IDLE` asynchronously and `bus_req` drops immediately. A late `bus_ack` arriving in `IDLE` is ignored.
- Latency with ack in the first `REQ` cycle:
  - cycle 0: `IDLE`, `stall`=1;
  - cycle 1: `REQ`, ack arrives;
  - cycle 2: `DONE`, `stall`=0, `load_data` is valid.
- Overall: 3 cycles per access, with `stall` high for 2 + N cycles for N wait cycles.
- `bus_ack` is sampled only in `REQ`. `bus_req` is never high in `IDLE` or `DONE`.
- The core holds all inputs stable while `stall`=1. Back-to-back accesses are therefore separated by at least one `IDLE` cycle.

## Structure
- Shared package `lsu_pkg`: the width localparams (`MW_B`, `MW_H`, `MW_W`, `MW_BU`, `MW_HU`) and the `lsu_state_t` enum.
- One combinational sub-module, `load_extend` (inputs: rdata, offset, width; output: the extended word), instanced once.
- The store lane logic stays inline.

## Test plan
- SB with address 0x1003, data 0xAB, ack at the first `REQ` → `bus_be`=1000, `bus_wdata`=0xABABABAB, `bus_addr`=0x1000; `stall` is high for 2 cycles.
- LB at 0x2001 with `bus_rdata`=0x0000F000 → `load_data`=0xFFFFFFF0. LBU on the same data → 0x000000F0.
- LH at 0x3002 with `bus_rdata`=0x80010000 and ack after 3 wait cycles → `load_data`=0xFFFF8001; `stall` is high for 5 cycles.
- LW at 0x4002 → `access_fault` pulses for one cycle, `bus_req` never rises, `stall`=0. `mem_width`=3'b011 gives the same result.
- LW with no ack → after 255 `REQ` cycles, `bus_error` pulses, `load_data`=0, `stall` drops.
- `reset` asserted during `REQ` → `bus_req`=0 immediately and the FSM is in `IDLE`; a subsequent ack has no effect.
